// File: rtl/motion_pkg.sv
// Shared encodings for the motion sequencer:
// FSM states, register addresses, CTRL/STATUS bits.
package motion_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ARM   = 3'd2,
    S_RUN   = 3'd3,
    S_STOP  = 3'd4,
    S_DWELL = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  localparam logic [15:0] REG_CTRL    = 16'h0000;
  localparam logic [15:0] REG_STEPSLO = 16'h0001;
  localparam logic [15:0] REG_STEPSHI = 16'h0002;
  localparam logic [15:0] REG_LEGS    = 16'h0003;
  localparam logic [15:0] REG_DWELL   = 16'h0004;
  localparam logic [15:0] REG_STATUS  = 16'h0005;
  localparam logic [15:0] REG_LEGCNT  = 16'h0006;
  localparam logic [15:0] REG_STATE   = 16'h0007;

  localparam int CTRL_START   = 0;
  localparam int CTRL_ABORT   = 1;
  localparam int CTRL_DIR0    = 2;
  localparam int CTRL_AUTOREV = 3;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_ABORTED = 2;
  localparam int ST_TIMEOUT = 3;
  localparam int ST_CFGERR  = 4;
  localparam int ST_DIR     = 5;

endpackage

// File: rtl/mseq_regfile.sv
// Register bus decode, move configuration,
// sticky status flags and read mux.
module mseq_regfile
  import motion_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr_i,
  input  logic        cs_i,
  input  logic        rd_i,
  input  logic        wr_i,
  input  logic [7:0]  data_i,
  output logic [7:0]  data_o,
  input  logic        busy_i,
  input  logic        dir_i,
  input  logic [7:0]  leg_cnt_i,
  input  logic [2:0]  state_i,
  input  logic        set_done_i,
  input  logic        set_abort_i,
  input  logic        set_timeout_i,
  input  logic        set_cfgerr_i,
  input  logic        clr_status_i,
  output logic        start_o,
  output logic        abort_o,
  output logic        dir0_o,
  output logic        auto_rev_o,
  output logic [15:0] steps_o,
  output logic [7:0]  legs_o,
  output logic [7:0]  dwell_o
);

  logic [7:0] steps_lo_q, steps_hi_q;
  logic [7:0] legs_q, dwell_q;
  logic       dir0_q, auto_rev_q;
  logic       done_q, aborted_q;
  logic       timeout_q, cfgerr_q;
  logic       wr_en, cfg_wr, ctrl_wr;

  assign wr_en   = cs_i && wr_i;
  assign cfg_wr  = wr_en && !busy_i;
  assign ctrl_wr = wr_en && (addr_i == REG_CTRL);

  assign start_o = ctrl_wr && data_i[CTRL_START];
  assign abort_o = ctrl_wr && data_i[CTRL_ABORT];

  // The START write may carry DIR0, so expose it on that same edge.
  assign dir0_o = (ctrl_wr && !busy_i) ? data_i[CTRL_DIR0] : dir0_q;
  assign auto_rev_o = auto_rev_q;
  assign steps_o    = {steps_hi_q, steps_lo_q};
  assign legs_o     = legs_q;
  assign dwell_o    = dwell_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      steps_lo_q <= 8'h00;
      steps_hi_q <= 8'h00;
      legs_q     <= 8'h00;
      dwell_q    <= 8'h00;
      dir0_q     <= 1'b0;
      auto_rev_q <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      timeout_q  <= 1'b0;
      cfgerr_q   <= 1'b0;
    end else begin
      if (cfg_wr) begin
        case (addr_i)
          REG_CTRL: begin
            dir0_q     <= data_i[CTRL_DIR0];
            auto_rev_q <= data_i[CTRL_AUTOREV];
          end
          REG_STEPSLO: steps_lo_q <= data_i;
          REG_STEPSHI: steps_hi_q <= data_i;
          REG_LEGS:    legs_q     <= data_i;
          REG_DWELL:   dwell_q    <= data_i;
          default: ;
        endcase
      end
      done_q    <= (done_q & ~clr_status_i) | set_done_i;
      aborted_q <= (aborted_q & ~clr_status_i) | set_abort_i;
      timeout_q <= (timeout_q & ~clr_status_i) | set_timeout_i;
      cfgerr_q  <= (cfgerr_q & ~clr_status_i) | set_cfgerr_i;
    end
  end

  always_comb begin
    data_o = 8'h00;
    if (cs_i && rd_i) begin
      case (addr_i)
        REG_STEPSLO: data_o = steps_lo_q;
        REG_STEPSHI: data_o = steps_hi_q;
        REG_LEGS:    data_o = legs_q;
        REG_DWELL:   data_o = dwell_q;
        REG_STATUS:  data_o = {2'b00, dir_i, cfgerr_q, timeout_q,
                               aborted_q, done_q, busy_i};
        REG_LEGCNT:  data_o = leg_cnt_i;
        REG_STATE:   data_o = {5'd0, state_i};
        default:     data_o = 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/motion_sequencer.sv
// Multi-leg move sequencer: drives motor enable/direction and
// the step counter limit, with dwell, auto-reverse and timeout.
module motion_sequencer
  import motion_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000,
  parameter logic [15:0] DWELL_UNIT     = 16'd100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic        cs,
  input  logic        rd,
  input  logic        wr,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        enable,
  output logic        motor_dir,
  output logic [15:0] limit_out,
  output logic        load_limit,
  input  logic        done_in,
  output logic        busy,
  output logic        seq_done
);

  state_e      state_q;
  logic        enable_q, dir_q, load_q, seq_done_q;
  logic [15:0] limit_q;
  logic [7:0]  leg_cnt_q;
  logic [23:0] run_tmr_q, dwell_tmr_q;

  logic        start, abort, dir0, auto_rev;
  logic [15:0] steps;
  logic [7:0]  legs, dwell;
  logic [2:0]  state_code;
  logic [23:0] dwell_total;
  logic        cfg_ok, idle, run_timeout, abort_hit;

  assign idle        = (state_q == S_IDLE);
  assign cfg_ok      = (steps != 16'd0) && (legs != 8'd0);
  assign abort_hit   = abort && !idle;
  assign run_timeout = (run_tmr_q >= TIMEOUT_CYCLES - 24'd1);
  assign dwell_total = {16'd0, dwell} * {8'd0, DWELL_UNIT};
  assign state_code  = state_q;

  assign busy       = !idle;
  assign enable     = enable_q;
  assign motor_dir  = dir_q;
  assign limit_out  = limit_q;
  assign load_limit = load_q;
  assign seq_done   = seq_done_q;

  mseq_regfile u_regs (
    .clk           (clk),
    .rst_n         (rst_n),
    .addr_i        (addr),
    .cs_i          (cs),
    .rd_i          (rd),
    .wr_i          (wr),
    .data_i        (data_in),
    .data_o        (data_out),
    .busy_i        (busy),
    .dir_i         (dir_q),
    .leg_cnt_i     (leg_cnt_q),
    .state_i       (state_code),
    .set_done_i    (!abort_hit && state_q == S_DONE),
    .set_abort_i   (abort_hit),
    .set_timeout_i (!abort_hit && state_q == S_RUN
                    && !done_in && run_timeout),
    .set_cfgerr_i  (start && idle && !cfg_ok),
    .clr_status_i  (start && idle),
    .start_o       (start),
    .abort_o       (abort),
    .dir0_o        (dir0),
    .auto_rev_o    (auto_rev),
    .steps_o       (steps),
    .legs_o        (legs),
    .dwell_o       (dwell)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      enable_q    <= 1'b0;
      dir_q       <= 1'b0;
      load_q      <= 1'b0;
      seq_done_q  <= 1'b0;
      limit_q     <= 16'd0;
      leg_cnt_q   <= 8'd0;
      run_tmr_q   <= 24'd0;
      dwell_tmr_q <= 24'd0;
    end else begin
      load_q     <= 1'b0;
      seq_done_q <= 1'b0;
      if (abort_hit) begin
        state_q  <= S_IDLE;
        enable_q <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (start && cfg_ok) begin
              state_q   <= S_LOAD;
              leg_cnt_q <= 8'd0;
              dir_q     <= dir0;
              limit_q   <= steps;
              load_q    <= 1'b1;
            end
          end
          S_LOAD: state_q <= S_ARM;
          // Hold off until the counter has dropped a stale done.
          S_ARM: begin
            if (!done_in) begin
              state_q   <= S_RUN;
              enable_q  <= 1'b1;
              run_tmr_q <= 24'd0;
            end
          end
          S_RUN: begin
            if (done_in) begin
              state_q  <= S_STOP;
              enable_q <= 1'b0;
            end else if (run_timeout) begin
              state_q  <= S_IDLE;
              enable_q <= 1'b0;
            end else if (run_tmr_q != 24'hFF_FFFF) begin
              run_tmr_q <= run_tmr_q + 24'd1;
            end
          end
          S_STOP: begin
            leg_cnt_q <= leg_cnt_q + 8'd1;
            if (auto_rev) dir_q <= ~dir_q;
            if (leg_cnt_q + 8'd1 == legs) begin
              state_q    <= S_DONE;
              seq_done_q <= 1'b1;
            end else if (dwell == 8'd0) begin
              state_q <= S_LOAD;
              limit_q <= steps;
              load_q  <= 1'b1;
            end else begin
              state_q     <= S_DWELL;
              dwell_tmr_q <= 24'd0;
            end
          end
          S_DWELL: begin
            if (dwell_tmr_q >= dwell_total - 24'd1) begin
              state_q <= S_LOAD;
              limit_q <= steps;
              load_q  <= 1'b1;
            end else begin
              dwell_tmr_q <= dwell_tmr_q + 24'd1;
            end
          end
          S_DONE: state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_motion_sequencer.sv
// Directed plus randomized bench for motion_sequencer with a
// behavioural step counter and a profile-level expectation model.
module tb_motion_sequencer;
  import motion_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] addr = '0;
  logic        cs = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [7:0]  data_in = '0;
  logic [7:0]  data_out;
  logic        enable, motor_dir, load_limit, done_in, busy, seq_done;
  logic [15:0] limit_out;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  motion_sequencer #(
    .TIMEOUT_CYCLES(24'd50),
    .DWELL_UNIT    (16'd100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr      (addr),
    .cs        (cs),
    .rd        (rd),
    .wr        (wr),
    .data_in   (data_in),
    .data_out  (data_out),
    .enable    (enable),
    .motor_dir (motor_dir),
    .limit_out (limit_out),
    .load_limit(load_limit),
    .done_in   (done_in),
    .busy      (busy),
    .seq_done  (seq_done)
  );

  // step counter stand-in; stall models a motor that never moves
  logic        stall = 1'b0;
  logic [15:0] sc_lim = '0, sc_cnt = '0;
  logic        sc_done = 1'b0;
  always @(posedge clk) begin
    if (load_limit) begin
      sc_lim  <= limit_out;
      sc_cnt  <= '0;
      sc_done <= 1'b0;
    end else if (enable && !stall && !sc_done) begin
      sc_cnt <= sc_cnt + 16'd1;
      if (sc_cnt + 16'd1 >= sc_lim) sc_done <= 1'b1;
    end
  end
  assign done_in = sc_done;

  // event log sampled on the falling edge
  int   cyc = 0;
  int   load_cyc[$];
  int   fall_cyc[$];
  logic dir_seq[$];
  int   sd_cnt = 0, en_cycles = 0, dir_glitch = 0;
  logic en_p = 1'b0, dir_p = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (load_limit) load_cyc.push_back(cyc);
    if (enable) en_cycles++;
    if (enable && !en_p) dir_seq.push_back(motor_dir);
    if (!enable && en_p) fall_cyc.push_back(cyc);
    if (enable && en_p && motor_dir !== dir_p) dir_glitch++;
    if (seq_done) sd_cnt++;
    en_p = enable;
    dir_p = motor_dir;
  end

  task automatic clr_mon();
    load_cyc.delete();
    fall_cyc.delete();
    dir_seq.delete();
    sd_cnt = 0;
    en_cycles = 0;
    dir_glitch = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; data_in = d; cs = 1'b1; wr = 1'b1;
    @(posedge clk);
    #1;
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [7:0] d);
    @(negedge clk);
    addr = a; cs = 1'b1; rd = 1'b1;
    #1;
    d = data_out;
    cs = 1'b0; rd = 1'b0;
  endtask

  task automatic cfg(input int steps, input int legs, input int dwell);
    bus_wr(REG_STEPSLO, 8'(steps));
    bus_wr(REG_STEPSHI, 8'(steps >> 8));
    bus_wr(REG_LEGS, 8'(legs));
    bus_wr(REG_DWELL, 8'(dwell));
  endtask

  int st_cyc = 0;
  task automatic start(input logic d0, input logic ar);
    clr_mon();
    bus_wr(REG_CTRL, {4'b0000, ar, d0, 2'b01});
    st_cyc = cyc;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy === 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle", {31'd0, busy}, 32'd0);
  endtask

  // profile-level expectations for a completed sequence
  task automatic check_seq(input int steps, input int legs,
                           input int dwell, input logic d0,
                           input logic ar);
    logic [7:0] rv;
    logic       dfin;
    dfin = d0 ^ (ar & legs[0]);
    chk("loads", load_cyc.size(), legs);
    chk("seq_done_cnt", sd_cnt, 1);
    chk("dir_glitch", dir_glitch, 0);
    chk("en_cycles", en_cycles, legs * (steps + 1));
    if (load_cyc.size() > 0)
      chk("start_latency", load_cyc[0] - st_cyc, 1);
    chk("dir_cnt", dir_seq.size(), legs);
    for (int i = 0; i < legs && i < dir_seq.size(); i++)
      chk("dir_leg", {31'd0, dir_seq[i]},
          {31'd0, d0 ^ (ar & i[0])});
    for (int i = 0; i + 1 < legs && i + 1 < load_cyc.size()
         && i < fall_cyc.size(); i++)
      chk("gap", load_cyc[i+1] - fall_cyc[i], dwell * 100 + 1);
    bus_rd(REG_LEGCNT, rv);
    chk("leg_cnt", {24'd0, rv}, legs);
    bus_rd(REG_STATUS, rv);
    chk("status_done", {24'd0, rv}, {26'd0, dfin, 5'b00010});
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    logic [7:0] rv;
    int n;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_enable", {31'd0, enable}, 0);
    chk("rst_dir", {31'd0, motor_dir}, 0);
    chk("rst_limit", {16'd0, limit_out}, 0);
    chk("rst_load", {31'd0, load_limit}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_seqdone", {31'd0, seq_done}, 0);
    chk("rst_dout", {24'd0, data_out}, 0);
    rst_n = 1'b1;
    bus_rd(REG_STATUS, rv);
    chk("rst_status", {24'd0, rv}, 0);
    bus_rd(REG_STATE, rv);
    chk("rst_state", {24'd0, rv}, 0);

    // single leg
    cfg(20, 1, 0);
    start(1'b0, 1'b0);
    wait_idle(500);
    check_seq(20, 1, 0, 1'b0, 1'b0);

    // four legs with dwell and auto reverse
    cfg(20, 4, 2);
    start(1'b0, 1'b1);
    wait_idle(3000);
    check_seq(20, 4, 2, 1'b0, 1'b1);

    // bad configuration, then a good start clears CFG_ERR
    cfg(0, 3, 0);
    start(1'b0, 1'b0);
    repeat (5) @(negedge clk);
    chk("cfg_busy", {31'd0, busy}, 0);
    chk("cfg_loads", load_cyc.size(), 0);
    bus_rd(REG_STATUS, rv);
    chk("cfg_status", {24'd0, rv}, 32'h10);
    bus_wr(REG_STEPSLO, 8'd20);
    start(1'b0, 1'b0);
    bus_rd(REG_STATUS, rv);
    chk("cfg_clear", {24'd0, rv}, 32'h01);
    wait_idle(1000);
    check_seq(20, 3, 0, 1'b0, 1'b0);

    // abort during leg 2 of 3
    start(1'b0, 1'b0);
    bus_wr(REG_LEGS, 8'd7);
    bus_rd(REG_LEGS, rv);
    chk("legs_locked", {24'd0, rv}, 3);
    n = 0;
    while (!(load_cyc.size() == 2 && enable === 1'b1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach", {31'd0, enable}, 1);
    bus_wr(REG_CTRL, 8'h02);
    chk("abort_enable", {31'd0, enable}, 0);
    chk("abort_busy", {31'd0, busy}, 0);
    bus_rd(REG_STATE, rv);
    chk("abort_state", {24'd0, rv}, 0);
    bus_rd(REG_STATUS, rv);
    chk("abort_status", {24'd0, rv}, 32'h04);
    bus_rd(REG_LEGCNT, rv);
    chk("abort_legcnt", {24'd0, rv}, 1);
    repeat (40) @(negedge clk);
    chk("abort_nodone", sd_cnt, 0);

    // timeout with a stalled motor
    stall = 1'b1;
    cfg(20, 1, 0);
    start(1'b0, 1'b0);
    wait_idle(300);
    chk("to_en_cycles", en_cycles, 50);
    chk("to_nodone", sd_cnt, 0);
    bus_rd(REG_STATUS, rv);
    chk("to_status", {24'd0, rv}, 32'h08);
    stall = 1'b0;

    // randomized profiles
    for (int k = 0; k < 6; k++) begin
      int s, l, d;
      logic d0, ar;
      s  = int'($urandom_range(1, 40));
      l  = int'($urandom_range(1, 4));
      d  = int'($urandom_range(0, 2));
      d0 = 1'($urandom_range(0, 1));
      ar = 1'($urandom_range(0, 1));
      cfg(s, l, d);
      start(d0, ar);
      wait_idle(3000);
      check_seq(s, l, d, d0, ar);
    end

    // reset while running
    cfg(20, 1, 0);
    start(1'b1, 1'b0);
    n = 0;
    while (enable !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rr_reach", {31'd0, enable}, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rr_enable", {31'd0, enable}, 0);
    chk("rr_busy", {31'd0, busy}, 0);
    chk("rr_dir", {31'd0, motor_dir}, 0);
    chk("rr_limit", {16'd0, limit_out}, 0);
    rst_n = 1'b1;
    bus_rd(REG_STEPSLO, rv);
    chk("rr_steps", {24'd0, rv}, 0);
    bus_rd(REG_LEGS, rv);
    chk("rr_legs", {24'd0, rv}, 0);
    bus_rd(REG_STATUS, rv);
    chk("rr_status", {24'd0, rv}, 0);
    bus_rd(16'h0009, rv);
    chk("unmapped", {24'd0, rv}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
